// File: rtl/mig_app_pkg.sv
// Shared types and constants for the MIG app-interface arbiter.
package mig_app_pkg;

    localparam int DEF_ADDR_W = 27;
    localparam int DEF_DATA_W = 128;

    localparam logic [2:0] CMD_WRITE = 3'b000;
    localparam logic [2:0] CMD_READ  = 3'b001;

    typedef enum logic [1:0] {
        WAIT_CAL,
        ARB,
        ISSUE
    } arb_state_t;

endpackage

// File: rtl/mig_tag_fifo.sv
// Requester-ID FIFO for outstanding MIG reads. One bit per entry (which
// requester issued the read), pointers carry an extra wrap bit so full and
// empty are told apart without a counter.
module mig_tag_fifo #(
    parameter int DEPTH = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic push,
    input  logic push_id,
    input  logic pop,
    output logic full,
    output logic empty,
    output logic head
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [DEPTH-1:0] mem;
    logic [PTR_W:0]   wr_ptr;
    logic [PTR_W:0]   rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                     (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign head    = mem[rd_ptr[PTR_W-1:0]];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Pointer update; push and pop in the same cycle both take effect.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + {{PTR_W{1'b0}}, 1'b1};
            if (do_pop)  rd_ptr <= rd_ptr + {{PTR_W{1'b0}}, 1'b1};
        end
    end

    // Tag storage; contents are meaningless while empty, so no reset.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[PTR_W-1:0]] <= push_id;
    end

endmodule

// File: rtl/mig_app_arbiter.sv
// Two-requester arbiter in front of one MIG 7-series app_* port (ui_clk).
// Each grant becomes one app_en command beat and, for writes, one
// app_wdf beat; read data is steered back using an in-order tag FIFO.
// Build option: define ARB_RD_PRIORITY_EN to let an eligible read win over
// a write; round-robin then only breaks ties between same-type requests.
module mig_app_arbiter
    import mig_app_pkg::*;
#(
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int MASK_W    = DATA_W / 8,
    parameter int TAG_DEPTH = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              init_calib_complete,
    input  logic              rq0_valid,
    input  logic              rq1_valid,
    output logic              rq0_ready,
    output logic              rq1_ready,
    input  logic              rq0_rd,
    input  logic              rq1_rd,
    input  logic [ADDR_W-1:0] rq0_addr,
    input  logic [ADDR_W-1:0] rq1_addr,
    input  logic [DATA_W-1:0] rq0_wdata,
    input  logic [DATA_W-1:0] rq1_wdata,
    input  logic [MASK_W-1:0] rq0_wmask,
    input  logic [MASK_W-1:0] rq1_wmask,
    output logic              rs0_valid,
    output logic              rs1_valid,
    output logic [DATA_W-1:0] rs_data,
    output logic [ADDR_W-1:0] app_addr,
    output logic [2:0]        app_cmd,
    output logic              app_en,
    output logic [DATA_W-1:0] app_wdf_data,
    output logic [MASK_W-1:0] app_wdf_mask,
    output logic              app_wdf_wren,
    output logic              app_wdf_end,
    input  logic              app_rdy,
    input  logic              app_wdf_rdy,
    input  logic [DATA_W-1:0] app_rd_data,
    input  logic              app_rd_data_valid,
    input  logic              app_rd_data_end
);

    arb_state_t        state;
    logic              rr_last;
    logic              cap_id;
    logic              cmd_done;
    logic              dat_done;
    logic              cmd_fin;
    logic              dat_fin;
    logic              elig0;
    logic              elig1;
    logic              win_id;
    logic              sel_rd;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic [MASK_W-1:0] sel_wmask;
    logic              tag_push;
    logic              tag_pop;
    logic              tag_full;
    logic              tag_empty;
    logic              tag_head;
    logic              err_rd_underflow;
    logic              unused_sigs;

    // BL8: exactly one data beat per read, so the end marker carries no information.
    assign unused_sigs = &{1'b0, app_rd_data_end, err_rd_underflow};

    // Eligibility and winner selection; a read needs a free tag slot.
    always_comb begin
        elig0  = rq0_valid && (!rq0_rd || !tag_full);
        elig1  = rq1_valid && (!rq1_rd || !tag_full);
        win_id = elig1 && !elig0;
        if (elig0 && elig1) begin
`ifdef ARB_RD_PRIORITY_EN
            if (rq0_rd != rq1_rd) win_id = rq1_rd;
            else                  win_id = ~rr_last;
`else
            win_id = ~rr_last;
`endif
        end
    end

    assign sel_rd    = win_id ? rq1_rd    : rq0_rd;
    assign sel_addr  = win_id ? rq1_addr  : rq0_addr;
    assign sel_wdata = win_id ? rq1_wdata : rq0_wdata;
    assign sel_wmask = win_id ? rq1_wmask : rq0_wmask;

    // A beat counts as finished if it already completed or completes this edge.
    assign cmd_fin  = cmd_done || (app_en && app_rdy);
    assign dat_fin  = dat_done || (app_wdf_wren && app_wdf_rdy);
    assign tag_push = (state == ISSUE) && app_en && app_rdy && (app_cmd == CMD_READ);
    assign tag_pop  = app_rd_data_valid && !tag_empty;

    mig_tag_fifo #(
        .DEPTH (TAG_DEPTH)
    ) u_tag_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (tag_push),
        .push_id (cap_id),
        .pop     (tag_pop),
        .full    (tag_full),
        .empty   (tag_empty),
        .head    (tag_head)
    );

    // Arbitration FSM: grant, then hold command/data beats until the MIG takes them.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= WAIT_CAL;
            rr_last      <= 1'b1;
            cap_id       <= 1'b0;
            cmd_done     <= 1'b0;
            dat_done     <= 1'b0;
            rq0_ready    <= 1'b0;
            rq1_ready    <= 1'b0;
            app_en       <= 1'b0;
            app_cmd      <= CMD_WRITE;
            app_addr     <= '0;
            app_wdf_wren <= 1'b0;
            app_wdf_end  <= 1'b0;
            app_wdf_data <= '0;
            app_wdf_mask <= '1;
        end else begin
            rq0_ready <= 1'b0;
            rq1_ready <= 1'b0;
            unique case (state)
                WAIT_CAL: begin
                    if (init_calib_complete) state <= ARB;
                end
                ARB: begin
                    if (!init_calib_complete) begin
                        state <= WAIT_CAL;
                    end else if (elig0 || elig1) begin
                        rq0_ready <= !win_id;
                        rq1_ready <= win_id;
                        rr_last   <= win_id;
                        cap_id    <= win_id;
                        app_en    <= 1'b1;
                        app_addr  <= sel_addr;
                        app_cmd   <= sel_rd ? CMD_READ : CMD_WRITE;
                        cmd_done  <= 1'b0;
                        dat_done  <= sel_rd;
                        if (!sel_rd) begin
                            app_wdf_wren <= 1'b1;
                            app_wdf_end  <= 1'b1;
                            app_wdf_data <= sel_wdata;
                            app_wdf_mask <= sel_wmask;
                        end
                        state <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (app_en && app_rdy) begin
                        app_en   <= 1'b0;
                        cmd_done <= 1'b1;
                    end
                    if (app_wdf_wren && app_wdf_rdy) begin
                        app_wdf_wren <= 1'b0;
                        app_wdf_end  <= 1'b0;
                        app_wdf_mask <= '1;
                        dat_done     <= 1'b1;
                    end
                    if (cmd_fin && dat_fin) begin
                        state <= init_calib_complete ? ARB : WAIT_CAL;
                    end
                end
                default: state <= WAIT_CAL;
            endcase
        end
    end

    // Read return: steer each beat to the oldest outstanding requester, one cycle later.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rs0_valid        <= 1'b0;
            rs1_valid        <= 1'b0;
            rs_data          <= '0;
            err_rd_underflow <= 1'b0;
        end else begin
            rs0_valid <= tag_pop && !tag_head;
            rs1_valid <= tag_pop && tag_head;
            if (tag_pop) rs_data <= app_rd_data;
            if (app_rd_data_valid && tag_empty) err_rd_underflow <= 1'b1;
        end
    end

endmodule
